// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, next-PC source encodings and the
// instruction-fetch state machine encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_e;

  // Byte-fetch states are 0..3 so the low bits double as the byte offset.
  typedef enum logic [2:0] {
    F0    = 3'd0,
    F1    = 3'd1,
    F2    = 3'd2,
    F3    = 3'd3,
    VALID = 3'd4,
    ERR   = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection among sequential, branch, jump-register and
// jump targets, plus detection of a misaligned jump-register target.
module next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [1:0]  pcsrc,
  input  logic [15:0] immediate,
  input  logic [25:0] jumpaddr,
  input  logic [31:0] regaddr,
  output logic [31:0] nextpc,
  output logic        misalign
);

  logic [31:0] br_off;

  // Word offset sign-extended and scaled to bytes.
  assign br_off = {{14{immediate[15]}}, immediate, 2'b00};

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // nextpc unassigned, which would otherwise infer a latch.
    nextpc = pc4;
    case (pcsrc_e'(pcsrc))
      PCSRC_SEQ: nextpc = pc4;
      PCSRC_BR:  nextpc = pc4 + br_off;
      PCSRC_JR:  nextpc = regaddr;
      PCSRC_J:   nextpc = {pc4[31:28], jumpaddr, 2'b00};
      default:   nextpc = pc4;
    endcase
  end

  assign misalign = (pcsrc_e'(pcsrc) == PCSRC_JR) && (regaddr[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch front end: owns the PC, reads four bytes from a byte-wide
// instruction memory, and hands the big-endian word to decode via valid/ready.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pcwre,
  input  logic [1:0]         pcsrc,
  input  logic [15:0]        immediate,
  input  logic [25:0]        jumpaddr,
  input  logic [31:0]        regaddr,
  input  logic [BYTE_W-1:0]  membyte,
  input  logic               instrready,
  output logic [31:0]        iaddr,
  output logic [INSTR_W-1:0] instruction,
  output logic               instrvalid,
  output logic [31:0]        pc,
  output logic [31:0]        pc4,
  output logic               misaligned
);

  fetch_state_e state;
  logic [31:0]  nextpc;
  logic         misalign;
  logic         accept;

  next_pc u_next_pc (
    .pc4       (pc4),
    .pcsrc     (pcsrc),
    .immediate (immediate),
    .jumpaddr  (jumpaddr),
    .regaddr   (regaddr),
    .nextpc    (nextpc),
    .misalign  (misalign)
  );

  assign pc4        = pc + 32'd4;
  assign instrvalid = (state == VALID);
  assign accept     = instrvalid && instrready && pcwre;

  // Address depends only on registered state, never on handshake inputs.
  assign iaddr = (state inside {F0, F1, F2, F3}) ? pc + {30'd0, state[1:0]} : pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and ordering between statements is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the instruction word is an ordinary register, not a memory, and
      // is cleared on reset so decode never sees stale bits from before it.
      state       <= F0;
      pc          <= RESET_PC;
      instruction <= '0;
      misaligned  <= 1'b0;
    end else begin
      case (state)
        F0: begin
          instruction[31:24] <= membyte;
          state              <= F1;
        end
        F1: begin
          instruction[23:16] <= membyte;
          state              <= F2;
        end
        F2: begin
          instruction[15:8] <= membyte;
          state             <= F3;
        end
        F3: begin
          instruction[7:0] <= membyte;
          state            <= VALID;
        end
        VALID: begin
          if (accept) begin
            if (misalign) begin
              misaligned <= 1'b1;
              state      <= ERR;
            end else begin
              pc    <= nextpc;
              state <= F0;
            end
          end
        end
        ERR:     state <= ERR;
        default: state <= F0;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, randomized accepts
// against a next-PC / memory reference model, and hold/reset/misalign corners.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcwre;
  logic [1:0]  pcsrc;
  logic [15:0] immediate;
  logic [25:0] jumpaddr;
  logic [31:0] regaddr;
  logic [7:0]  membyte;
  logic        instrready;
  logic [31:0] iaddr;
  logic [31:0] instruction;
  logic        instrvalid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misaligned;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pcwre       (pcwre),
    .pcsrc       (pcsrc),
    .immediate   (immediate),
    .jumpaddr    (jumpaddr),
    .regaddr     (regaddr),
    .membyte     (membyte),
    .instrready  (instrready),
    .iaddr       (iaddr),
    .instruction (instruction),
    .instrvalid  (instrvalid),
    .pc          (pc),
    .pc4         (pc4),
    .misaligned  (misaligned)
  );

  // Instruction memory decodes only the low 8 address bits.
  logic [7:0] mem [256];
  assign membyte = mem[iaddr[7:0]];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  src;
    logic [15:0] imm;
    logic [25:0] ja;
    logic [31:0] ra;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    return {mem[8'(a)], mem[8'(a + 1)], mem[8'(a + 2)], mem[8'(a + 3)]};
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] s,
                                             input logic [15:0] im, input logic [25:0] ja,
                                             input logic [31:0] ra);
    logic [31:0] p4;
    int off;
    p4  = cur + 32'd4;
    off = $signed(im);
    case (s)
      2'd0:    return p4;
      2'd1:    return p4 + 32'(off * 4);
      2'd2:    return ra;
      default: return (p4 & 32'hF000_0000) + (32'(ja) * 32'd4);
    endcase
  endfunction

  // Runs the fetch phase, checking each byte address, bounded to 8 cycles.
  task automatic wait_valid(input logic [31:0] exp_pc, output int n);
    n = 0;
    while (!instrvalid && n < 8) begin
      instrready = 1'($urandom);
      pcwre      = 1'($urandom);
      check("iaddr_fetch", iaddr, exp_pc + 32'(n));
      tick();
      n++;
    end
    check("valid_timeout", {31'd0, instrvalid}, 32'd1);
  endtask

  task automatic do_accept(input logic [1:0] s, input logic [15:0] im,
                           input logic [25:0] ja, input logic [31:0] ra);
    pcsrc = s; immediate = im; jumpaddr = ja; regaddr = ra;
    pcwre = 1'b1; instrready = 1'b1;
    tick();
    instrready = 1'b0;
    pcsrc = 2'($urandom); immediate = 16'($urandom);
    jumpaddr = 26'($urandom); regaddr = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] mpc;
    logic [31:0] held_instr;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h02; mem[1] = 8'h10; mem[2] = 8'h80; mem[3] = 8'h20;

    vecs[0]  = '{2'd0, 16'h0000, 26'h0,       32'h0,         32'h0000_0004};
    vecs[1]  = '{2'd0, 16'h1234, 26'h0,       32'h0,         32'h0000_0008};
    vecs[2]  = '{2'd1, 16'hFFFE, 26'h0,       32'h0,         32'h0000_0004};
    vecs[3]  = '{2'd0, 16'h0000, 26'h0,       32'h0,         32'h0000_0008};
    vecs[4]  = '{2'd1, 16'h0003, 26'h0,       32'h0,         32'h0000_0018};
    vecs[5]  = '{2'd2, 16'h0000, 26'h0,       32'hF000_0010, 32'hF000_0010};
    vecs[6]  = '{2'd3, 16'h0000, 26'h0000040, 32'h0,         32'hF000_0100};
    vecs[7]  = '{2'd2, 16'h0000, 26'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[8]  = '{2'd0, 16'h0000, 26'h0,       32'h0,         32'h0000_0000};
    vecs[9]  = '{2'd1, 16'h8000, 26'h0,       32'h0,         32'hFFFE_0004};
    vecs[10] = '{2'd3, 16'h0000, 26'h3FFFFFF, 32'h0,         32'hFFFF_FFFC};

    rst_n = 1'b0; pcwre = 1'b1; pcsrc = 2'd0; immediate = '0;
    jumpaddr = '0; regaddr = '0; instrready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, instrvalid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc4, 32'h4);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);

    // First fetch after reset release: bytes 0..3, valid after the 4th edge.
    rst_n = 1'b1;
    wait_valid(32'h0, n);
    check("first_latency", 32'(n), 32'd4);
    check("first_instr", instruction, 32'h0210_8020);
    instrready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pcwre = 1'($urandom);
      tick();
      check("noready_valid", {31'd0, instrvalid}, 32'd1);
      check("noready_instr", instruction, 32'h0210_8020);
    end

    mpc = 32'h0;
    for (int i = 0; i < 11; i++) begin
      wait_valid(mpc, n);
      check("vec_latency", 32'(n), (i == 0) ? 32'd0 : 32'd4);
      check("vec_instr", instruction, model_instr(mpc));
      check("vec_pc", pc, mpc);
      check("vec_pc4", pc4, mpc + 32'd4);
      check("vec_iaddr_valid", iaddr, mpc);
      do_accept(vecs[i].src, vecs[i].imm, vecs[i].ja, vecs[i].ra);
      check("vec_valid_drop", {31'd0, instrvalid}, 32'd0);
      check("vec_next_pc", pc, vecs[i].exp_pc);
      mpc = vecs[i].exp_pc;
    end

    // Randomized accepts with stalls and withdrawn ready.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  s;
      logic [15:0] im;
      logic [25:0] ja;
      logic [31:0] ra;
      wait_valid(mpc, n);
      check("rnd_latency", 32'(n), 32'd4);
      check("rnd_instr", instruction, model_instr(mpc));
      held_instr = instruction;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        case ($urandom_range(0, 2))
          0:       begin instrready = 1'b0; pcwre = 1'b0; end
          1:       begin instrready = 1'b1; pcwre = 1'b0; end
          default: begin instrready = 1'b0; pcwre = 1'b1; end
        endcase
        pcsrc = 2'($urandom); regaddr = $urandom;
        tick();
        check("rnd_stall_valid", {31'd0, instrvalid}, 32'd1);
        check("rnd_stall_pc", pc, mpc);
        check("rnd_stall_instr", instruction, held_instr);
      end
      s  = 2'($urandom);
      im = 16'($urandom);
      ja = 26'($urandom);
      ra = $urandom & 32'hFFFF_FFFC;
      do_accept(s, im, ja, ra);
      mpc = model_next(mpc, s, im, ja, ra);
      check("rnd_next_pc", pc, mpc);
      check("rnd_misaligned", {31'd0, misaligned}, 32'd0);
    end

    // Halt: ready high, write enable low for 10 cycles.
    wait_valid(mpc, n);
    held_instr = instruction;
    pcwre = 1'b0; instrready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pcsrc = 2'($urandom); regaddr = $urandom;
      tick();
      check("halt_pc", pc, mpc);
      check("halt_instr", instruction, held_instr);
    end
    do_accept(2'd0, 16'h0, 26'h0, 32'h0);
    mpc = mpc + 32'd4;
    check("halt_release_pc", pc, mpc);

    // Reset in the middle of a fetch (state F2).
    pcwre = 1'b1;
    tick();
    tick();
    check("f2_iaddr", iaddr, mpc + 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, instrvalid}, 32'd0);
    check("midrst_instr", instruction, 32'h0);
    check("midrst_iaddr", iaddr, 32'h0);
    check("midrst_pc4", pc4, 32'h4);
    tick();
    rst_n = 1'b1;

    // Misaligned jump register latches the error state.
    wait_valid(32'h0, n);
    do_accept(2'd0, 16'h0, 26'h0, 32'h0);
    wait_valid(32'h4, n);
    do_accept(2'd2, 16'h0, 26'h0, 32'h0000_0042);
    check("mis_flag", {31'd0, misaligned}, 32'd1);
    check("mis_valid", {31'd0, instrvalid}, 32'd0);
    check("mis_pc", pc, 32'h4);
    check("mis_iaddr", iaddr, 32'h4);
    for (int i = 0; i < 6; i++) begin
      pcwre = 1'b1; instrready = 1'b1;
      pcsrc = 2'($urandom); regaddr = $urandom;
      tick();
      check("err_valid", {31'd0, instrvalid}, 32'd0);
      check("err_pc", pc, 32'h4);
      check("err_flag", {31'd0, misaligned}, 32'd1);
    end
    instrready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("err_rst_flag", {31'd0, misaligned}, 32'd0);
    check("err_rst_pc", pc, 32'h0);
    tick();
    rst_n = 1'b1;
    wait_valid(32'h0, n);
    check("err_rst_instr", instruction, 32'h0210_8020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction fetch front end of the CPU: owns the program counter, drives the byte address into the 8-bit-wide instruction memory, and assembles four sequential bytes into one 32-bit big-endian instruction word. It presents the word to the decode/control stage with a valid/ready handshake. On acceptance, it computes the next PC from the sequential, branch, jump and jump-register sources supplied by control.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  rising-edge clock
- RST_n  in  1  asynchronous active-low reset
- PCWre  in  1  PC write enable; 0 holds the current instruction (halt/stall)
- PCSrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump-register, 11 jump
- Immediate  in  16  branch offset in words, sign-extended
- JumpAddr  in  26  jump target field
- RegAddr  in  32  jump-register target (rs value)
- MemByte  in  8  byte returned combinationally by instruction memory at IAddr
- InstrReady  in  1  decode accepts the current instruction
- IAddr  out  32  byte address to instruction memory
- Instruction  out  32  assembled instruction word
- InstrValid  out  1  Instruction is complete and stable
- PC  out  32  address of the current instruction
- PC4  out  32  PC+4, used for link/branch
- Misaligned  out  1  sticky flag: a jump-register target had nonzero bits [1:0]

## Operation
- FSM states: F0, F1, F2, F3, VALID, ERR.
- In Fk (k=0..3), IAddr = PC + k. On the clock edge, MemByte is written to Instruction[31-8k -: 8], so byte 0 is the MSB. Fk advances to Fk+1, and F3 advances to VALID.
- In VALID, InstrValid=1 and Instruction is held unchanged. IAddr = PC.
- Acceptance occurs in a cycle where InstrValid && InstrReady && PCWre. On acceptance, PC <= next PC and the state returns to F0.
- If InstrReady=1 and PCWre=0, the block stays in VALID and PC is held. This is the halt behaviour.
- Next PC by PCSrc:
  - 00: PC4
  - 01: PC4 + (sext(Immediate) << 2)
  - 10: RegAddr
  - 11: {PC4[31:28], JumpAddr, 2'b00}
- All next-PC arithmetic is 32-bit modulo 2^32 and wraps silently. Instruction memory decodes only the low address bits it needs.
- Misaligned jump register: on acceptance with PCSrc=10 and RegAddr[1:0]≠0:
  - PC is not updated.
  - Misaligned is set to 1 and stays set.
  - The state moves to ERR.
- ERR has InstrValid=0 and IAddr=PC, and the block stays there until reset.
- PCSrc, Immediate, JumpAddr and RegAddr are sampled only in the accepting cycle and ignored otherwise.
- Reset at any point, including mid-fetch, aborts the fetch:
  - state=F0, PC=RESET_PC
  - Instruction=0, InstrValid=0, Misaligned=0
  - IAddr=RESET_PC, PC4=RESET_PC+4

## Timing
- After RST_n deasserts, the first instruction is valid on the 5th rising edge: edges 1-4 capture bytes 0-3, and edge 5's cycle shows VALID.
  - Edge count from RST_n release: F0 is active in cycle 0; InstrValid rises after the 4th edge.
- Minimum 5 cycles per instruction: 4 fetch cycles plus 1 accept cycle.
- InstrValid falls on the edge following acceptance. The new PC is visible on the same edge.
- IAddr and PC4 are combinational from registered PC and state only. There is no path from InstrReady or PCSrc to IAddr.
- InstrReady is not required to be held. Withdrawing it while valid only delays acceptance.

## Structure
- Shared package cpu_pkg holds:
  - PCSrc encodings: PCSRC_SEQ, PCSRC_BR, PCSRC_JR, PCSRC_J.
  - Fetch state enum.
  - INSTR_W=32 and BYTE_W=8.
- Sub-module next_pc: purely combinational. Inputs are PC4, PCSrc, Immediate, JumpAddr and RegAddr. Outputs are NextPC and Misalign.
- Top-level pc_fetch contains the FSM, PC register and byte assembly.

## Test plan
- Reset release with memory bytes 0-3 = 8'h02,8'h10,8'h80,8'h20 and InstrReady=0:
  - IAddr sequence is 0,1,2,3.
  - Instruction=32'h0210_8020 with InstrValid=1 after edge 4, and it holds there.
- Accept with PCSrc=00:
  - PC becomes 4 and IAddr restarts at 4.
  - Back-to-back accepts give one instruction per 5 cycles.
- Branch at PC=8 with Immediate=16'hFFFE:
  - Next PC=4.
  - With Immediate=16'h0003, next PC=24.
- Jump at PC=32'hF000_0010 with JumpAddr=26'h0000040: next PC=32'hF000_0100.
- Jump-register with RegAddr=32'h0000_0042:
  - Misaligned=1, InstrValid=0, PC unchanged.
  - The block stays in ERR until RST_n is pulsed, after which PC=RESET_PC.
- Combined hold and reset cases:
  - PCWre=0 with InstrReady=1 held for 10 cycles: PC and Instruction are unchanged.
  - Asserting RST_n=0 during F2 immediately clears InstrValid and Instruction and sets IAddr=RESET_PC.
